// File: rtl/mdu_sequencer.sv
// mdu_sequencer: iterative RV32M multiply/divide unit.
// One op per start pulse, one bit per cycle (shift-add multiply, restoring
// divide), busy while working, then a single-cycle done with a held result.
module mdu_sequencer #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic             kill,
   input  logic [2:0]       Funct3,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   localparam int unsigned CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t             state_q, state_nxt;
   logic               busy_nxt;
   logic               load_c, step_c, fix_c;

   logic [2:0]         f3_q;
   logic               neg_a_q, neg_b_q;
   logic [WIDTH-1:0]   mag_a_q, mag_b_q;
   logic [CW-1:0]      cnt_q;
   logic [WIDTH:0]     acc_q;
   logic [WIDTH-1:0]   lo_q;

   logic               sgn_a_c, sgn_b_c;
   logic               neg_a_c, neg_b_c;
   logic [WIDTH-1:0]   mag_a_c, mag_b_c;

   logic [WIDTH:0]     mul_sum_c;
   logic [WIDTH:0]     div_sh_c;
   logic [WIDTH:0]     div_sub_c;
   logic               div_ge_c;

   logic [2*WIDTH-1:0] prod_c, prod_fix_c;
   logic               div0_c;
   logic [WIDTH-1:0]   quot_c, rem_mag_c, rem_c, res_c;

   // Operand signedness from Funct3, and magnitudes of the incoming operands
   always_comb begin
      sgn_a_c = 1'b0;
      sgn_b_c = 1'b0;
      unique case (Funct3)
         3'b000, 3'b001, 3'b100, 3'b110: begin
            sgn_a_c = 1'b1;
            sgn_b_c = 1'b1;
         end
         3'b010: sgn_a_c = 1'b1;
         default: ;
      endcase
      neg_a_c = sgn_a_c & op_a[WIDTH-1];
      neg_b_c = sgn_b_c & op_b[WIDTH-1];
      mag_a_c = neg_a_c ? WIDTH'(-op_a) : op_a;
      mag_b_c = neg_b_c ? WIDTH'(-op_b) : op_b;
   end

   // One iteration step: add-and-shift for multiply, trial subtract for divide
   always_comb begin
      mul_sum_c = acc_q + (lo_q[0] ? {1'b0, mag_a_q} : '0);
      div_sh_c  = {acc_q[WIDTH-1:0], lo_q[WIDTH-1]};
      div_ge_c  = (div_sh_c >= {1'b0, mag_b_q});
      div_sub_c = div_sh_c - {1'b0, mag_b_q};
   end

   // Sign fix-up, divide-by-zero override and result selection
   always_comb begin
      prod_c     = {acc_q[WIDTH-1:0], lo_q};
      prod_fix_c = (neg_a_q ^ neg_b_q) ? (2*WIDTH)'(-prod_c) : prod_c;
      div0_c     = (mag_b_q == '0);
      quot_c     = div0_c ? '1 : ((neg_a_q ^ neg_b_q) ? WIDTH'(-lo_q) : lo_q);
      rem_mag_c  = div0_c ? mag_a_q : acc_q[WIDTH-1:0];
      rem_c      = neg_a_q ? WIDTH'(-rem_mag_c) : rem_mag_c;
      unique case (f3_q)
         3'b000:                 res_c = prod_fix_c[WIDTH-1:0];
         3'b001, 3'b010, 3'b011: res_c = prod_fix_c[2*WIDTH-1:WIDTH];
         3'b100, 3'b101:         res_c = quot_c;
         default:                res_c = rem_c;
      endcase
   end

   // Next-state and control decode; kill outranks start
   always_comb begin
      state_nxt = state_q;
      load_c    = 1'b0;
      step_c    = 1'b0;
      fix_c     = 1'b0;
      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (kill) begin
               state_nxt = S_IDLE;
            end else if (start) begin
               state_nxt = S_CALC;
               load_c    = 1'b1;
            end else begin
               state_nxt = S_IDLE;
            end
         end
         S_CALC: begin
            if (kill) begin
               state_nxt = S_IDLE;
            end else begin
               step_c = 1'b1;
               if (cnt_q == CW'(WIDTH - 1)) state_nxt = S_FIX;
            end
         end
         S_FIX: begin
            if (kill) begin
               state_nxt = S_IDLE;
            end else begin
               fix_c     = 1'b1;
               state_nxt = S_DONE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
      busy_nxt = (state_nxt == S_CALC) || (state_nxt == S_FIX);
   end

   // State register with registered busy/done
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state_q <= state_nxt;
         busy    <= busy_nxt;
         done    <= fix_c;
      end
   end

   // Datapath: operand latch on start, iterate in CALC, capture result in FIX
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         f3_q    <= '0;
         neg_a_q <= 1'b0;
         neg_b_q <= 1'b0;
         mag_a_q <= '0;
         mag_b_q <= '0;
         cnt_q   <= '0;
         acc_q   <= '0;
         lo_q    <= '0;
         result  <= '0;
      end else begin
         if (load_c) begin
            f3_q    <= Funct3;
            neg_a_q <= neg_a_c;
            neg_b_q <= neg_b_c;
            mag_a_q <= mag_a_c;
            mag_b_q <= mag_b_c;
            cnt_q   <= '0;
            acc_q   <= '0;
            lo_q    <= Funct3[2] ? mag_a_c : mag_b_c;
         end else if (step_c) begin
            cnt_q <= CW'(cnt_q + 1'b1);
            if (f3_q[2]) begin
               acc_q <= div_ge_c ? div_sub_c : div_sh_c;
               lo_q  <= {lo_q[WIDTH-2:0], div_ge_c};
            end else begin
               acc_q <= {1'b0, mul_sum_c[WIDTH:1]};
               lo_q  <= {mul_sum_c[0], lo_q[WIDTH-1:1]};
            end
         end
         if (fix_c) result <= res_c;
      end
   end

endmodule

// File: tb/tb_mdu_sequencer.sv
// tb_mdu_sequencer: directed and randomized checks of mdu_sequencer
// against a 64-bit arithmetic reference model.
module tb_mdu_sequencer;

   localparam int unsigned W = 32;

   logic         clk;
   logic         reset_n;
   logic         start;
   logic         kill;
   logic [2:0]   funct3;
   logic [W-1:0] op_a;
   logic [W-1:0] op_b;
   logic         busy;
   logic         done;
   logic [W-1:0] result;

   int tests;
   int fails;

   mdu_sequencer #(.WIDTH(W)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (start),
      .kill    (kill),
      .Funct3  (funct3),
      .op_a    (op_a),
      .op_b    (op_b),
      .busy    (busy),
      .done    (done),
      .result  (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Watchdog so the run always ends
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // RV32M reference computed with wide integer arithmetic
   function automatic logic [31:0] ref_model(input logic [2:0] f,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
      int          ia, ib;
      longint      sa, sb, p;
      longint unsigned ua, ub, up;
      ia = int'(a);
      ib = int'(b);
      sa = ia;
      sb = ib;
      ua = {32'd0, a};
      ub = {32'd0, b};
      case (f)
         3'd0: begin p = sa * sb; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * longint'(ub); return p[63:32]; end
         3'd3: begin up = ua * ub; return up[63:32]; end
         3'd4: begin
            if (b == 32'd0) return 32'hFFFF_FFFF;
            p = sa / sb;
            return p[31:0];
         end
         3'd5: begin
            if (b == 32'd0) return 32'hFFFF_FFFF;
            up = ua / ub;
            return up[31:0];
         end
         3'd6: begin
            if (b == 32'd0) return a;
            p = sa % sb;
            return p[31:0];
         end
         default: begin
            if (b == 32'd0) return a;
            up = ua % ub;
            return up[31:0];
         end
      endcase
   endfunction

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 5))
         0:       return 32'h0000_0000;
         1:       return 32'h0000_0001;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h8000_0000;
         4:       return 32'h7FFF_FFFF;
         default: return 32'($urandom);
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one start for a single edge, then scramble the operand inputs
   task automatic start_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      start  = 1'b1;
      funct3 = f;
      op_a   = a;
      op_b   = b;
      tick();
      start  = 1'b0;
      funct3 = 3'($urandom);
      op_a   = 32'($urandom);
      op_b   = 32'($urandom);
   endtask

   // Watch a running op from sample k0 up to the expected done sample
   task automatic wait_done(input string tag, input logic [31:0] exp, input int k0, input int b0);
      int busy_cnt;
      int done_at;
      busy_cnt = b0;
      done_at  = -1;
      for (int k = k0; k <= W + 1; k++) begin
         if (k > k0) tick();
         if (busy === 1'b1) busy_cnt++;
         if (done === 1'b1 && done_at < 0) done_at = k;
      end
      check({tag, " busy_cycles"}, 32'(busy_cnt), 32'(W + 1));
      check({tag, " done_at"}, 32'(done_at), 32'(W + 1));
      check({tag, " result"}, result, exp);
   endtask

   // Run n cycles and report whether done was ever seen
   task automatic quiet_cycles(input string tag, input int n, input logic [31:0] held);
      int seen;
      seen = 0;
      for (int k = 0; k < n; k++) begin
         tick();
         if (done !== 1'b0) seen++;
      end
      check({tag, " no_done"}, 32'(seen), 32'd0);
      check({tag, " result_held"}, result, held);
   endtask

   initial begin
      int          b;
      logic [2:0]  f;
      logic [31:0] a, bb;

      tests   = 0;
      fails   = 0;
      reset_n = 1'b0;
      start   = 1'b0;
      kill    = 1'b0;
      funct3  = 3'd0;
      op_a    = '0;
      op_b    = '0;
      tick();
      tick();
      check("reset busy", 32'(busy), 32'd0);
      check("reset done", 32'(done), 32'd0);
      check("reset result", result, 32'd0);
      reset_n = 1'b1;
      tick();

      // Directed vectors
      start_op(3'd0, 32'd7, 32'hFFFF_FFFD);
      wait_done("MUL 7*-3", 32'hFFFF_FFEB, 0, 0);
      tick();
      check("done pulse width", 32'(done), 32'd0);
      check("result held after done", result, 32'hFFFF_FFEB);

      start_op(3'd1, 32'h8000_0000, 32'h8000_0000);
      wait_done("MULH min*min", 32'h4000_0000, 0, 0);
      start_op(3'd3, 32'h8000_0000, 32'h8000_0000);
      wait_done("MULHU", 32'h4000_0000, 0, 0);
      start_op(3'd2, 32'hFFFF_FFFF, 32'd2);
      wait_done("MULHSU -1*2", 32'hFFFF_FFFF, 0, 0);
      start_op(3'd4, 32'hFFFF_FFF9, 32'd2);
      wait_done("DIV -7/2", 32'hFFFF_FFFD, 0, 0);
      start_op(3'd6, 32'hFFFF_FFF9, 32'd2);
      wait_done("REM -7/2", 32'hFFFF_FFFF, 0, 0);
      start_op(3'd5, 32'd100, 32'd7);
      wait_done("DIVU 100/7", 32'd14, 0, 0);
      start_op(3'd7, 32'd100, 32'd7);
      wait_done("REMU 100/7", 32'd2, 0, 0);
      start_op(3'd5, 32'd100, 32'd0);
      wait_done("DIVU by zero", 32'hFFFF_FFFF, 0, 0);
      start_op(3'd6, 32'hFFFF_FF9C, 32'd0);
      wait_done("REM by zero", 32'hFFFF_FF9C, 0, 0);
      start_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_done("DIV overflow", 32'h8000_0000, 0, 0);
      start_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_done("REM overflow", 32'd0, 0, 0);
      tick();

      // Kill mid-CALC: busy drops at once, no done, result untouched
      start_op(3'd0, 32'd9, 32'd9);
      for (int k = 0; k < 9; k++) tick();
      kill = 1'b1;
      tick();
      kill = 1'b0;
      check("kill busy low", 32'(busy), 32'd0);
      quiet_cycles("kill", 40, 32'd0);

      // Start while busy is ignored
      start_op(3'd0, 32'd7, 32'hFFFF_FFFD);
      b = 0;
      for (int k = 0; k < 4; k++) begin
         if (busy === 1'b1) b++;
         tick();
      end
      if (busy === 1'b1) b++;
      start  = 1'b1;
      funct3 = 3'd5;
      op_a   = 32'd100;
      op_b   = 32'd7;
      tick();
      start  = 1'b0;
      wait_done("start while busy", 32'hFFFF_FFEB, 5, b);

      // Kill in DONE beats a simultaneous start
      start = 1'b1;
      kill  = 1'b1;
      funct3 = 3'd0;
      op_a   = 32'd2;
      op_b   = 32'd2;
      tick();
      start = 1'b0;
      kill  = 1'b0;
      check("kill over start busy", 32'(busy), 32'd0);
      quiet_cycles("kill over start", 40, 32'hFFFF_FFEB);

      // Reset mid-op clears outputs and drops the op
      start_op(3'd0, 32'd11, 32'd13);
      for (int k = 0; k < 19; k++) tick();
      reset_n = 1'b0;
      tick();
      check("midop reset busy", 32'(busy), 32'd0);
      check("midop reset done", 32'(done), 32'd0);
      check("midop reset result", result, 32'd0);
      reset_n = 1'b1;
      quiet_cycles("after reset", 40, 32'd0);

      // Back-to-back: second start issued in the DONE cycle
      start_op(3'd3, 32'd3, 32'd5);
      wait_done("b2b MULHU 3*5", 32'd0, 0, 0);
      start_op(3'd0, 32'd3, 32'd5);
      wait_done("b2b MUL 3*5", 32'd15, 0, 0);

      // Randomized ops, mixing back-to-back and idle gaps
      for (int i = 0; i < 40; i++) begin
         f  = 3'($urandom_range(0, 7));
         a  = pick_operand();
         bb = pick_operand();
         start_op(f, a, bb);
         wait_done($sformatf("rand%0d f3=%0d a=%h b=%h", i, f, a, bb),
                   ref_model(f, a, bb), 0, 0);
         if ($urandom_range(0, 1) == 1) tick();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
